// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: fetch control inputs, instruction-memory read port
// and the valid/ready handshake toward decode.
interface instr_fetch_if;
   logic        fetch_en;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [16:0] im_instr;
   logic [16:0] if_instr;
   logic [15:0] if_pc;
   logic        if_valid;
   logic        id_ready;

   modport master (
      input  fetch_en, redirect, redirect_pc, im_instr, id_ready,
      output im_addr, im_rd_en, if_instr, if_pc, if_valid
   );

   modport slave (
      output fetch_en, redirect, redirect_pc, im_instr, id_ready,
      input  im_addr, im_rd_en, if_instr, if_pc, if_valid
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to instruction memory
// and buffers returned {pc, instr} pairs in a prefetch FIFO for decode.
module instr_fetch #(
   parameter int          DEPTH    = 3,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic         clk,
   input  logic         rst_n,
   instr_fetch_if.master bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 2);

   typedef struct packed {
      logic [15:0] pc;
      logic [16:0] instr;
   } entry_t;

   entry_t             fifo_mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [15:0]        fetch_pc;
   logic [15:0]        inflight_pc;
   logic               started;
   logic               inflight;

   logic [CNT_W-1:0]   occupancy;
   logic               issue;
   logic               push;
   logic               pop;
   logic               head_valid;
   entry_t             head;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Occupancy counts the outstanding read so a returning word always has a slot.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      occupancy  = count + CNT_W'(inflight);
      issue      = started && bus.fetch_en && !bus.redirect
                   && (occupancy < CNT_W'(DEPTH));
      push       = inflight && !bus.redirect;
      head_valid = (count != '0) && !bus.redirect;
      pop        = head_valid && bus.id_ready;
      head       = fifo_mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only.
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
         started     <= 1'b0;
         inflight    <= 1'b0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         started  <= 1'b1;
         inflight <= issue;
         if (issue)
            inflight_pc <= fetch_pc;

         if (bus.redirect)
            fetch_pc <= bus.redirect_pc;
         else if (issue)
            fetch_pc <= fetch_pc + 16'd1;

         // Redirect drops buffered entries and the returning word alike.
         if (bus.redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= next_ptr(wr_ptr);
            if (pop)
               rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // NOTE: FIFO storage has no reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= '{pc: inflight_pc, instr: bus.im_instr};
   end

   always_comb begin
      bus.im_addr  = fetch_pc;
      bus.im_rd_en = issue;
      bus.if_valid = head_valid;
      bus.if_pc    = (count != '0) ? head.pc    : '0;
      bus.if_instr = (count != '0) ? head.instr : '0;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: startup vector table, scoreboard of the
// in-order PC stream, and hand sequences for stall, redirect, wrap and reset.
module tb_instr_fetch;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic clk = 1'b0;
   logic rst_n;

   instr_fetch_if bus ();

   instr_fetch #(.DEPTH(3), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int n_accept = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [16:0] mem_word(input logic [15:0] a);
      return {1'b0, a} + 17'h100;
   endfunction

   // Memory model: address registered on posedge, data driven on negedge.
   logic [15:0] mem_addr_q = '0;
   initial bus.im_instr = '0;
   always @(posedge clk) if (bus.im_rd_en) mem_addr_q <= bus.im_addr;
   always @(negedge clk) bus.im_instr <= mem_word(mem_addr_q);

   // Scoreboard: expected PCs of the in-order stream reaching decode.
   logic [15:0] exp_q[$];
   logic [15:0] gen_pc;

   function automatic void top_up();
      while (exp_q.size() < 4) begin
         exp_q.push_back(gen_pc);
         gen_pc = gen_pc + 16'd1;
      end
   endfunction

   function automatic void sb_restart(input logic [15:0] start);
      exp_q.delete();
      gen_pc = start;
      top_up();
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.if_valid && bus.id_ready) begin
         logic [15:0] pc;
         pc = exp_q.pop_front();
         check("sb_pc", 32'(bus.if_pc), 32'(pc));
         check("sb_instr", 32'(bus.if_instr), 32'(mem_word(pc)));
         top_up();
         n_accept++;
      end
   end

   typedef struct {
      logic        fetch_en;
      logic        id_ready;
      logic        exp_rd_en;
      logic [15:0] exp_addr;
      logic        exp_valid;
      logic [15:0] exp_pc;
      logic [16:0] exp_instr;
   } vec_t;

   vec_t vecs[6];

   task automatic run_startup();
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end else begin
            rst_n = 1'b1;
            sb_restart(RESET_PC);
         end
         bus.fetch_en = vecs[i].fetch_en;
         bus.id_ready = vecs[i].id_ready;
         @(negedge clk);
         check($sformatf("start%0d_rd_en", i), 32'(bus.im_rd_en), 32'(vecs[i].exp_rd_en));
         check($sformatf("start%0d_addr", i),  32'(bus.im_addr),  32'(vecs[i].exp_addr));
         check($sformatf("start%0d_valid", i), 32'(bus.if_valid), 32'(vecs[i].exp_valid));
         check($sformatf("start%0d_pc", i),    32'(bus.if_pc),    32'(vecs[i].exp_pc));
         check($sformatf("start%0d_instr", i), 32'(bus.if_instr), 32'(vecs[i].exp_instr));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accepts(input string name, input int n, input int budget);
      int base;
      int c;
      base = n_accept;
      c = 0;
      while ((n_accept - base) < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      check(name, 32'((n_accept - base) >= n), 32'd1);
   endtask

   task automatic pulse_redirect(input logic [15:0] target);
      bus.redirect    = 1'b1;
      bus.redirect_pc = target;
      sb_restart(target);
      @(posedge clk);
      #1;
      bus.redirect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Startup timeline, one row per sample after P0..P4 (row 0 precedes P0).
      vecs[0] = '{1'b1, 1'b1, 1'b0, RESET_PC,      1'b0, 16'h0000, 17'h00000};
      vecs[1] = '{1'b1, 1'b1, 1'b1, RESET_PC,      1'b0, 16'h0000, 17'h00000};
      vecs[2] = '{1'b1, 1'b1, 1'b1, RESET_PC + 1,  1'b0, 16'h0000, 17'h00000};
      vecs[3] = '{1'b1, 1'b1, 1'b1, RESET_PC + 2,  1'b1, RESET_PC, 17'h00100};
      vecs[4] = '{1'b1, 1'b1, 1'b1, RESET_PC + 3,  1'b1, RESET_PC + 1, 17'h00101};
      vecs[5] = '{1'b1, 1'b1, 1'b1, RESET_PC + 4,  1'b1, RESET_PC + 2, 17'h00102};

      rst_n           = 1'b0;
      bus.fetch_en    = 1'b1;
      bus.id_ready    = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      sb_restart(RESET_PC);
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.if_valid), 32'd0);
      check("rst_rd_en", 32'(bus.im_rd_en), 32'd0);
      check("rst_addr",  32'(bus.im_addr),  32'(RESET_PC));
      check("rst_pc",    32'(bus.if_pc),    32'd0);
      check("rst_instr", 32'(bus.if_instr), 32'd0);

      run_startup();
      wait_accepts("steady_accepts", 8, 10);

      // Backpressure: head holds, issue stops once the FIFO plus in-flight is full.
      bus.id_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("bp_head_pc", 32'(bus.if_pc), 32'(exp_q[0]));
      end
      check("bp_rd_en", 32'(bus.im_rd_en), 32'd0);
      check("bp_valid", 32'(bus.if_valid), 32'd1);
      @(posedge clk);
      #1;
      bus.id_ready = 1'b1;
      wait_accepts("bp_resume_accepts", 6, 12);

      // Build FIFO=2 with one read in flight, then redirect.
      bus.id_ready = 1'b0;
      @(posedge clk);
      #1;
      check("pre_redir_rd_en", 32'(bus.im_rd_en), 32'd0);
      check("pre_redir_valid", 32'(bus.if_valid), 32'd1);
      bus.id_ready    = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0040;
      sb_restart(16'h0040);
      #1;
      check("redir_valid_gated", 32'(bus.if_valid), 32'd0);
      check("redir_rd_en",       32'(bus.im_rd_en), 32'd0);
      @(posedge clk);
      #1;
      bus.redirect = 1'b0;
      @(negedge clk);
      check("redir_r1_rd_en", 32'(bus.im_rd_en), 32'd1);
      check("redir_r1_addr",  32'(bus.im_addr),  32'h0040);
      check("redir_r1_valid", 32'(bus.if_valid), 32'd0);
      begin
         int c;
         c = 0;
         while (!bus.if_valid && c < 4) begin
            @(negedge clk);
            c++;
         end
         check("redir_target_valid", 32'(bus.if_valid), 32'd1);
         check("redir_target_pc",    32'(bus.if_pc),    32'h0040);
      end
      @(posedge clk);
      #1;
      wait_accepts("redir_accepts", 4, 8);

      // Wrap across 16'hFFFF; the scoreboard expects FFFE, FFFF, 0000, 0001, ...
      pulse_redirect(16'hFFFE);
      wait_accepts("wrap_accepts", 5, 12);

      // fetch_en low: no issue, pipeline drains, then resumes contiguously.
      bus.fetch_en = 1'b0;
      #1;
      check("fe_off_rd_en_now", 32'(bus.im_rd_en), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("fe_off_rd_en", 32'(bus.im_rd_en), 32'd0);
      end
      check("fe_off_drained", 32'(bus.if_valid), 32'd0);
      @(posedge clk);
      #1;
      bus.fetch_en = 1'b1;
      #1;
      check("fe_on_rd_en", 32'(bus.im_rd_en), 32'd1);
      check("fe_on_addr",  32'(bus.im_addr),  32'(exp_q[0]));
      wait_accepts("fe_on_accepts", 4, 10);

      // Asynchronous reset with a full FIFO, applied between clock edges.
      bus.id_ready = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("pre_arst_valid", 32'(bus.if_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.if_valid), 32'd0);
      check("arst_rd_en", 32'(bus.im_rd_en), 32'd0);
      check("arst_pc",    32'(bus.if_pc),    32'd0);
      check("arst_instr", 32'(bus.if_instr), 32'd0);
      check("arst_addr",  32'(bus.im_addr),  32'(RESET_PC));
      @(posedge clk);
      #1;
      run_startup();
      wait_accepts("post_arst_accepts", 4, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
